// File: rtl/spi_sram_master.sv
// spi_sram_master: SPI mode-0 initiator for 23LC1024-style serial SRAMs.
// Define SPI_SRAM_BURST_EN to keep cs_n low across sequential requests.
module spi_sram_master #(
  parameter int CLK_DIV       = 2,
  parameter int CSH_CYCLES    = 4,
  parameter int BURST_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [23:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  output logic        mem_ready,
  output logic [7:0]  mem_rdata,
  output logic        mem_rvalid,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  localparam int M1 =
    (CLK_DIV > CSH_CYCLES) ? CLK_DIV : CSH_CYCLES;
  localparam int CMAX =
    (M1 > BURST_TIMEOUT) ? M1 : BURST_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] D1   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CSH1 = CW'(CSH_CYCLES - 1);
`ifdef SPI_SRAM_BURST_EN
  localparam logic [CW-1:0] TMO1 = CW'(BURST_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_CSHIGH,
    S_OPEN
  } state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [5:0]     bitn, bitn_d;
  logic [39:0]    shreg, shreg_d;
  logic [39:0]    frame;
  logic [7:0]     rx, rx_d;
  logic           op_wr, op_wr_d;
  logic           sck_d, cs_n_d, mosi_d;
  logic           ready_d, rvalid_d;
  logic [7:0]     rdata_d;
  logic           accept;
`ifdef SPI_SRAM_BURST_EN
  logic [23:0]    next_addr, next_d;
  logic           pend, pend_d;
`endif

  assign accept = mem_req && mem_ready;

  // Frame image for the request currently on the bus.
  always_comb begin
    frame = {mem_wr ? 8'h02 : 8'h03,
             mem_addr,
             mem_wr ? mem_wdata : 8'h00};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bitn_d   = bitn;
    shreg_d  = shreg;
    rx_d     = rx;
    op_wr_d  = op_wr;
    sck_d    = sck;
    cs_n_d   = cs_n;
    mosi_d   = mosi;
    ready_d  = mem_ready;
    rdata_d  = mem_rdata;
    rvalid_d = 1'b0;
`ifdef SPI_SRAM_BURST_EN
    next_d   = next_addr;
    pend_d   = pend;
`endif
    unique case (state)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = D1;
          bitn_d  = 6'd39;
          shreg_d = frame;
          op_wr_d = mem_wr;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = frame[39];
          ready_d = 1'b0;
`ifdef SPI_SRAM_BURST_EN
          next_d  = mem_addr + 24'd1;
`endif
        end
      end
      S_SETUP: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          state_d = S_SHIFT;
          sck_d   = 1'b1;
          cnt_d   = D1;
        end
      end
      S_SHIFT: begin
        if (sck && cnt == D1)
          rx_d = {rx[6:0], miso};
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else if (!sck) begin
          sck_d = 1'b1;
          cnt_d = D1;
        end else begin
          sck_d   = 1'b0;
          cnt_d   = D1;
          shreg_d = {shreg[38:0], 1'b0};
          if (bitn != '0) begin
            bitn_d = bitn - 1'b1;
            mosi_d = shreg[38];
          end else begin
            mosi_d = 1'b0;
`ifdef SPI_SRAM_BURST_EN
            state_d  = S_OPEN;
            cnt_d    = TMO1;
            ready_d  = 1'b1;
            rvalid_d = !op_wr;
            rdata_d  = op_wr ? mem_rdata : rx_d;
`else
            state_d = S_HOLD;
`endif
          end
        end
      end
      S_HOLD: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          state_d = S_CSHIGH;
          cs_n_d  = 1'b1;
          cnt_d   = CSH1;
`ifndef SPI_SRAM_BURST_EN
          rvalid_d = !op_wr;
          rdata_d  = op_wr ? mem_rdata : rx;
`endif
        end
      end
      S_CSHIGH: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          state_d = S_IDLE;
          ready_d = 1'b1;
`ifdef SPI_SRAM_BURST_EN
          if (pend) begin
            pend_d  = 1'b0;
            state_d = S_SETUP;
            ready_d = 1'b0;
            cs_n_d  = 1'b0;
            mosi_d  = shreg[39];
            cnt_d   = D1;
          end
`endif
        end
      end
`ifdef SPI_SRAM_BURST_EN
      S_OPEN: begin
        if (accept) begin
          ready_d = 1'b0;
          cnt_d   = D1;
          if (mem_wr == op_wr &&
              mem_addr == next_addr) begin
            state_d = S_SETUP;
            bitn_d  = 6'd7;
            shreg_d = {frame[7:0], 32'h0};
            mosi_d  = frame[7];
            next_d  = next_addr + 24'd1;
          end else begin
            state_d = S_HOLD;
            bitn_d  = 6'd39;
            shreg_d = frame;
            op_wr_d = mem_wr;
            next_d  = mem_addr + 24'd1;
            pend_d  = 1'b1;
          end
        end else if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          state_d = S_HOLD;
          ready_d = 1'b0;
          cnt_d   = D1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bitn       <= '0;
      shreg      <= '0;
      rx         <= '0;
      op_wr      <= 1'b0;
      sck        <= 1'b0;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      mem_rvalid <= 1'b0;
`ifdef SPI_SRAM_BURST_EN
      next_addr  <= '0;
      pend       <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bitn       <= bitn_d;
      shreg      <= shreg_d;
      rx         <= rx_d;
      op_wr      <= op_wr_d;
      sck        <= sck_d;
      cs_n       <= cs_n_d;
      mosi       <= mosi_d;
      mem_ready  <= ready_d;
      mem_rdata  <= rdata_d;
      mem_rvalid <= rvalid_d;
`ifdef SPI_SRAM_BURST_EN
      next_addr  <= next_d;
      pend       <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_sram_master.sv
// tb_spi_sram_master: directed + randomized bench with an SPI SRAM model.
// Burst scenarios compile in when SPI_SRAM_BURST_EN is defined.
module tb_spi_sram_master;

  localparam int D   = 2;
  localparam int CSH = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_wr = 1'b0;
  logic [23:0] mem_addr = '0;
  logic [7:0]  mem_wdata = '0;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_sram_master #(
    .CLK_DIV(D),
    .CSH_CYCLES(CSH),
    .BURST_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .sck(sck),
    .cs_n(cs_n),
    .mosi(mosi),
    .miso(miso)
  );

  // SPI SRAM slave (sequential mode) plus bus event counters.
  logic [7:0]  smem [int];
  logic [7:0]  mmem [int];
  logic [7:0]  fr [$];
  logic [7:0]  sb = '0;
  logic [7:0]  scmd = '0;
  logic [7:0]  sbyte;
  logic [23:0] saddr = '0;
  logic        sck_q = 1'b0;
  logic        cs_q = 1'b1;
  int sbits = 0;
  int frames = 0;
  int pulses = 0;
  int lows = 0;
  int rv_cnt = 0;

  always @(posedge clk) begin
    int k;
    logic [23:0] a;
    sck_q <= sck;
    cs_q  <= cs_n;
    if (mem_rvalid) rv_cnt++;
    if (cs_q && !cs_n) lows++;
    if (cs_n) begin
      sbits = 0;
    end else if (sck && !sck_q) begin
      if (sbits == 0) begin
        fr.delete();
        frames++;
      end
      sb = {sb[6:0], mosi};
      sbits++;
      pulses++;
      if (sbits % 8 == 0) begin
        fr.push_back(sb);
        if (sbits == 8)
          scmd = sb;
        else if (sbits <= 32)
          saddr = {saddr[15:0], sb};
        else if (scmd == 8'h02) begin
          a = saddr + 24'((sbits - 40) / 8);
          smem[int'(a)] = sb;
        end
      end
    end else if (!sck && sck_q && sbits >= 32 &&
                 scmd == 8'h03) begin
      k = sbits - 32;
      a = saddr + 24'(k / 8);
      sbyte = smem.exists(int'(a)) ? smem[int'(a)] : 8'h00;
      miso <= sbyte[7 - (k % 8)];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge; return at the negedge where
  // mem_ready is seen again, with event cycle numbers (cycle 0 = accept).
  task automatic run_req(input logic wr,
                         input logic [23:0] a,
                         input logic [7:0] d,
                         input bit hold,
                         output int t_csr,
                         output int t_rdy,
                         output int n_rv,
                         output logic [7:0] rv_data,
                         output int t_rv);
    int k;
    t_csr = -1;
    t_rdy = -1;
    n_rv = 0;
    rv_data = 8'h00;
    t_rv = -1;
    k = 0;
    while (!mem_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 32'(mem_ready), 32'd1);
    mem_req = 1'b1;
    mem_wr = wr;
    mem_addr = a;
    mem_wdata = d;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      mem_req = 1'b0;
      mem_wr = 1'($urandom);
      mem_addr = 24'($urandom);
      mem_wdata = 8'($urandom);
    end
    for (k = 1; k < 2000; k++) begin
      if (mem_rvalid) begin
        n_rv++;
        rv_data = mem_rdata;
        t_rv = k;
      end
      if (cs_n && t_csr < 0) t_csr = k;
      if (mem_ready) begin
        t_rdy = k;
        break;
      end
      @(negedge clk);
    end
    chk("frame_done", 32'(t_rdy >= 0), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc, tr, nr, tv, f0, r0, l0, p0, k;
    logic [7:0] rd, dv;
    logic [23:0] pool [4];
    logic [23:0] a;
    logic w;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rvalid", 32'(mem_rvalid), 32'd0);
    chk("rst_rdata", 32'(mem_rdata), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", 32'(mem_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      pool[i] = 24'($urandom);
      dv = 8'($urandom);
      smem[int'(pool[i])] = dv;
      mmem[int'(pool[i])] = dv;
    end

`ifndef SPI_SRAM_BURST_EN
    // Single read with known preload.
    smem[int'(24'h012345)] = 8'hA5;
    mmem[int'(24'h012345)] = 8'hA5;
    r0 = rv_cnt;
    run_req(1'b0, 24'h012345, 8'h00, 1'b0,
            tc, tr, nr, rd, tv);
    chk("t1_size", 32'(fr.size()), 32'd5);
    chk("t1_cmd", 32'(fr[0]), 32'h03);
    chk("t1_a2", 32'(fr[1]), 32'h01);
    chk("t1_a1", 32'(fr[2]), 32'h23);
    chk("t1_a0", 32'(fr[3]), 32'h45);
    chk("t1_csr", 32'(tc), 32'(1 + 81 * D));
    chk("t1_rv_t", 32'(tv), 32'(1 + 81 * D));
    chk("t1_nrv", 32'(nr), 32'd1);
    chk("t1_rdata", 32'(rd), 32'h0A5);
    chk("t1_rdy", 32'(tr), 32'(1 + 81 * D + CSH));

    // Write then read back.
    mmem[int'(24'h000010)] = 8'h3C;
    run_req(1'b1, 24'h000010, 8'h3C, 1'b0,
            tc, tr, nr, rd, tv);
    chk("t2_w_nrv", 32'(nr), 32'd0);
    chk("t2_w_cmd", 32'(fr[0]), 32'h02);
    chk("t2_w_data", 32'(fr[4]), 32'h3C);
    chk("t2_slave_mem", 32'(smem[int'(24'h000010)]), 32'h3C);
    chk("t2_csh", 32'(tr - tc), 32'(CSH));
    chk("t2_rdata_held", 32'(mem_rdata), 32'h0A5);
    run_req(1'b0, 24'h000010, 8'h00, 1'b0,
            tc, tr, nr, rd, tv);
    chk("t2_r_nrv", 32'(nr), 32'd1);
    chk("t2_r_data", 32'(rd), 32'(mmem[int'(24'h000010)]));
    chk("t2_r_csh", 32'(tr - tc), 32'(CSH));

    // mem_req held high across a whole frame.
    f0 = frames;
    dv = 8'($urandom);
    mmem[int'(pool[0])] = dv;
    run_req(1'b1, pool[0], dv, 1'b1,
            tc, tr, nr, rd, tv);
    chk("t3_frames1", 32'(frames - f0), 32'd1);
    chk("t3_rdy", 32'(tr), 32'(1 + 81 * D + CSH));
    run_req(1'b1, pool[0], dv, 1'b0,
            tc, tr, nr, rd, tv);
    chk("t3_frames2", 32'(frames - f0), 32'd2);
    chk("t3_mem", 32'(smem[int'(pool[0])]), 32'(dv));

    // Reset in the middle of a read frame.
    r0 = rv_cnt;
    mem_req = 1'b1;
    mem_wr = 1'b0;
    mem_addr = pool[1];
    @(posedge clk);
    @(negedge clk);
    mem_req = 1'b0;
    k = 0;
    while (sbits < 20 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("t4_reach_bit20", 32'(sbits), 32'd20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_cs_n", 32'(cs_n), 32'd1);
    chk("t4_sck", 32'(sck), 32'd0);
    chk("t4_rdata_rst", 32'(mem_rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_ready", 32'(mem_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_no_rvalid", 32'(rv_cnt - r0), 32'd0);
    run_req(1'b0, pool[1], 8'h00, 1'b0,
            tc, tr, nr, rd, tv);
    chk("t4_after_data", 32'(rd), 32'(mmem[int'(pool[1])]));
    chk("t4_after_rdy", 32'(tr), 32'(1 + 81 * D + CSH));

    // Randomized reads/writes over a small address pool.
    for (int i = 0; i < 8; i++) begin
      a = pool[$urandom_range(0, 3)];
      w = 1'($urandom);
      dv = 8'($urandom);
      if (w) mmem[int'(a)] = dv;
      run_req(w, a, dv, 1'b0, tc, tr, nr, rd, tv);
      chk("rnd_cmd", 32'(fr[0]), w ? 32'h02 : 32'h03);
      chk("rnd_addr", 32'({fr[1], fr[2], fr[3]}), 32'(a));
      chk("rnd_nrv", 32'(nr), w ? 32'd0 : 32'd1);
      if (!w) chk("rnd_rdata", 32'(rd), 32'(mmem[int'(a)]));
      chk("rnd_rdy", 32'(tr), 32'(1 + 81 * D + CSH));
    end
    for (int i = 0; i < 4; i++)
      chk("rnd_mem", 32'(smem[int'(pool[i])]),
          32'(mmem[int'(pool[i])]));
`else
    // Burst of three reads across the 24-bit wrap.
    for (int i = 0; i < 3; i++) begin
      a = 24'hFFFFFE + 24'(i);
      dv = 8'($urandom);
      smem[int'(a)] = dv;
      mmem[int'(a)] = dv;
    end
    l0 = lows;
    p0 = pulses;
    run_req(1'b0, 24'hFFFFFE, 8'h00, 1'b0,
            tc, tr, nr, rd, tv);
    chk("t5_first_rdy", 32'(tr), 32'(1 + 80 * D));
    chk("t5_first_rv", 32'(tv), 32'(1 + 80 * D));
    chk("t5_first_data", 32'(rd), 32'(mmem[int'(24'hFFFFFE)]));
    chk("t5_first_cs", 32'(cs_n), 32'd0);
    for (int i = 1; i < 3; i++) begin
      a = 24'hFFFFFE + 24'(i);
      run_req(1'b0, a, 8'h00, 1'b0, tc, tr, nr, rd, tv);
      chk("t5_cont_rdy", 32'(tr), 32'(1 + 16 * D));
      chk("t5_cont_rv", 32'(tv), 32'(1 + 16 * D));
      chk("t5_cont_data", 32'(rd), 32'(mmem[int'(a)]));
      chk("t5_cont_cs", 32'(tc), 32'hFFFFFFFF);
    end
    chk("t5_lows", 32'(lows - l0), 32'd1);
    chk("t5_pulses", 32'(pulses - p0), 32'd56);
    chk("t5_cmd", 32'(fr[0]), 32'h03);
    chk("t5_addr", 32'({fr[1], fr[2], fr[3]}), 32'hFFFFFE);

    // Write, then non-sequential-op read, then idle timeout.
    dv = 8'($urandom);
    smem[int'(24'h000101)] = dv;
    mmem[int'(24'h000101)] = dv;
    dv = 8'($urandom);
    mmem[int'(24'h000100)] = dv;
    run_req(1'b1, 24'h000100, dv, 1'b0,
            tc, tr, nr, rd, tv);
    chk("t6_w_nrv", 32'(nr), 32'd0);
    chk("t6_w_mem", 32'(smem[int'(24'h000100)]), 32'(dv));
    l0 = lows;
    run_req(1'b0, 24'h000101, 8'h00, 1'b0,
            tc, tr, nr, rd, tv);
    chk("t6_csr", 32'(tc), 32'(1 + D));
    chk("t6_lows", 32'(lows - l0), 32'd1);
    chk("t6_cmd", 32'(fr[0]), 32'h03);
    chk("t6_rdy", 32'(tr), 32'(1 + 81 * D + CSH));
    chk("t6_data", 32'(rd), 32'(mmem[int'(24'h000101)]));
    repeat (TMO + D - 1) @(negedge clk);
    chk("t6_open_cs", 32'(cs_n), 32'd0);
    @(negedge clk);
    chk("t6_timeout_cs", 32'(cs_n), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
